main_mem_resp: RTL and testbench
================================

MAIN_MEM_RESP -- requirements
Module: main_mem_resp

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, meaning number of 32-bit words in the backing array (power of 2, at least 2).
REQ-002 SHALL have parameter READ_LATENCY, default 4, meaning clock edges from read acceptance to ack (at least 1).
REQ-003 SHALL have parameter WRITE_LATENCY, default 4, meaning clock edges from write acceptance to ack (at least 1).
REQ-004 SHALL have port clk, input, 1 bit: clock, rising-edge active.
REQ-005 SHALL have port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port mem_read_req, input, 1 bit: level read request from cache (line refill).
REQ-007 SHALL have port mem_write_req, input, 1 bit: level write request from cache (dirty write-back).
REQ-008 SHALL have port mem_addr, input, 32 bits: byte address of request.
REQ-009 SHALL have port mem_data_in, input, 32 bits: write data from cache.
REQ-010 SHALL have port mem_data_out, output, 32 bits: read data returned to cache.
REQ-011 SHALL have port Main_mem_ack, output, 1 bit: single-cycle completion pulse.
REQ-012 SHALL have port mem_busy, output, 1 bit: high whenever a request is in flight.

Function
REQ-013 SHALL implement an FSM with states IDLE, READ_WAIT, WRITE_WAIT and ACK.
REQ-014 SHALL compute the word index as mem_addr[log2(MEM_DEPTH)+1:2], ignoring addr[1:0] and the upper bits, so addresses wrap modulo MEM_DEPTH words.
REQ-015 SHALL accept a request only in IDLE, on a rising edge where mem_read_req or mem_write_req is high, latching the index and mem_data_in at that edge.
REQ-016 SHALL give write priority when both requests are high in IDLE, so write-back precedes refill; the read is then accepted after the write completes if still held.
REQ-017 SHALL, on acceptance, load a latency counter with LATENCY-1 and enter the matching WAIT state; if LATENCY = 1 it SHALL enter ACK directly.
REQ-018 SHALL decrement the counter once per cycle in WAIT and move to ACK on the edge where the counter equals 0, so Main_mem_ack is high in the cycle following edge E0+LATENCY-1, where E0 is the acceptance edge.
REQ-019 SHALL assert Main_mem_ack for exactly one cycle, only in ACK, then return to IDLE unconditionally.
REQ-020 SHALL, for a read, register array[index] onto mem_data_out on the edge entering ACK, so the data is valid in the same cycle as Main_mem_ack.
REQ-021 SHALL hold mem_data_out at its last read value until the next read completes; writes SHALL NOT change mem_data_out.
REQ-022 SHALL, for a write, commit the latched data to array[index] on the edge entering ACK, never earlier.
REQ-023 SHALL abort a request whose level drops while in WAIT: return to IDLE on the next edge, with no ack, no array write and no mem_data_out update.
REQ-024 SHALL ignore changes to mem_addr and mem_data_in after acceptance.
REQ-025 SHALL drive mem_busy = (state != IDLE), combinationally from the state register.
REQ-026 SHALL accept a request still held in the IDLE cycle after ACK as a new transaction; the minimum spacing is LATENCY+1 cycles per transaction.

Reset
REQ-027 SHALL, while reset = 0, force state IDLE, counter 0, Main_mem_ack 0, mem_data_out 32'h0 and mem_busy 0, regardless of clk.
REQ-028 SHALL, on reset assertion mid-transaction, drop the transaction with no ack; a pending write SHALL NOT be committed.
REQ-029 SHALL NOT clear the storage array on reset; its contents SHALL be preserved across reset.

Verification
REQ-030 Write then read, defaults: write addr 0x10, data 0xDEADBEEF -> ack 4 edges after acceptance, busy high 4 cycles; then read addr 0x10 -> mem_data_out 0xDEADBEEF with ack, 4 edges after acceptance.
REQ-031 Simultaneous requests: read and write both high, addr 0x20, data 0x12345678 -> write acked first; read held -> second ack returns 0x12345678.
REQ-032 Address wrap: write 0xA5A5A5A5 to 0x400 (MEM_DEPTH=256) -> read of 0x0 returns 0xA5A5A5A5; read of 0x3 returns the same word.
REQ-033 Abort: write 0x55 to 0x8, drop request after 2 cycles -> no ack, mem_busy low next cycle; later read of 0x8 returns the prior value.
REQ-034 Reset mid-write: assert reset during WRITE_WAIT -> ack 0, mem_busy 0, mem_data_out 0 immediately; the word is unchanged after reset releases.
REQ-035 READ_LATENCY=1 -> ack and data in the cycle immediately after the acceptance edge; back-to-back held read re-accepted after one IDLE cycle.

Source files
------------

// File: rtl/main_mem_resp.sv
// Main-memory responder for a cache: one word-wide backing array serving a single
// refill (read) or write-back (write) at a time, each with its own fixed latency.
module main_mem_resp #(
  parameter int MEM_DEPTH     = 256,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_req,
  input  logic        mem_write_req,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data_in,
  output logic [31:0] mem_data_out,
  output logic        Main_mem_ack,
  output logic        mem_busy
);

  localparam int AW      = $clog2(MEM_DEPTH);
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CW-1:0] RD_LOAD = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2,
    ACK        = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic [CW-1:0]   cnt_dec;
  logic [AW-1:0]   addr_idx;
  logic [AW-1:0]   idx_q;
  logic [AW-1:0]   op_idx;
  logic [31:0]     data_q;
  logic [31:0]     op_data;
  logic            accept;
  logic            mem_we;
  logic            rd_load;

  logic [31:0]     mem [MEM_DEPTH];

  // Byte offset and bits above the array size are don't-care: addresses wrap.
  assign addr_idx = mem_addr[AW+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:AW+2], mem_addr[1:0]};

  assign cnt_dec = cnt - CW'(1);

  // A latency of 1 commits straight out of IDLE, so the live inputs are used then.
  assign op_idx  = (state == IDLE) ? addr_idx    : idx_q;
  assign op_data = (state == IDLE) ? mem_data_in : data_q;

  // The WAIT states advance to ACK on the edge where the counter reaches zero,
  // which places the ack in the cycle after edge E0+LATENCY-1.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves one
    // unassigned and no latch can be inferred.
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    mem_we     = 1'b0;
    rd_load    = 1'b0;

    case (state)
      IDLE: begin
        if (mem_write_req) begin
          accept = 1'b1;
          if (WRITE_LATENCY == 1) begin
            state_next = ACK;
            mem_we     = 1'b1;
          end else begin
            state_next = WRITE_WAIT;
            cnt_next   = WR_LOAD;
          end
        end else if (mem_read_req) begin
          accept = 1'b1;
          if (READ_LATENCY == 1) begin
            state_next = ACK;
            rd_load    = 1'b1;
          end else begin
            state_next = READ_WAIT;
            cnt_next   = RD_LOAD;
          end
        end
      end

      READ_WAIT: begin
        if (!mem_read_req) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_dec == '0) begin
          state_next = ACK;
          cnt_next   = '0;
          rd_load    = 1'b1;
        end else begin
          cnt_next = cnt_dec;
        end
      end

      WRITE_WAIT: begin
        if (!mem_write_req) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_dec == '0) begin
          state_next = ACK;
          cnt_next   = '0;
          mem_we     = 1'b1;
        end else begin
          cnt_next = cnt_dec;
        end
      end

      ACK: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      idx_q  <= '0;
      data_q <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        idx_q  <= addr_idx;
        data_q <= mem_data_in;
      end
    end
  end

  // NOTE: the array has no reset branch so its contents survive reset; the write
  // enable is qualified with reset so a held request cannot commit during reset.
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      mem[op_idx] <= op_data;
    end
  end

  // Read data is loaded only on the edge entering ACK for a read; writes and
  // aborted reads leave the last returned value in place.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_data_out <= '0;
    end else if (rd_load) begin
      mem_data_out <= mem[op_idx];
    end
  end

  assign Main_mem_ack = (state == ACK);
  assign mem_busy     = (state != IDLE);

endmodule

// File: tb/tb_main_mem_resp.sv
// Scoreboard bench for main_mem_resp: directed transactions push expected acks into
// per-instance queues that negedge monitors pop and compare against the DUT.
module tb_main_mem_resp;

  localparam int RL0 = 4;
  localparam int WL0 = 4;
  localparam int RL1 = 1;
  localparam int WL1 = 2;

  logic        clk = 1'b0;
  logic        reset;
  int          cyc = 0;

  logic        rd0, wr0, ack0, busy0;
  logic [31:0] addr0, din0, dout0;
  logic        rd1, wr1, ack1, busy1;
  logic [31:0] addr1, din1, dout1;

  typedef struct {
    string       name;
    logic        is_read;
    logic [31:0] data;
    int          ack_cyc;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t m0, m1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  main_mem_resp #(.MEM_DEPTH(256), .READ_LATENCY(RL0), .WRITE_LATENCY(WL0)) dut0 (
    .clk(clk), .reset(reset), .mem_read_req(rd0), .mem_write_req(wr0),
    .mem_addr(addr0), .mem_data_in(din0), .mem_data_out(dout0),
    .Main_mem_ack(ack0), .mem_busy(busy0)
  );

  main_mem_resp #(.MEM_DEPTH(16), .READ_LATENCY(RL1), .WRITE_LATENCY(WL1)) dut1 (
    .clk(clk), .reset(reset), .mem_read_req(rd1), .mem_write_req(wr1),
    .mem_addr(addr1), .mem_data_in(din1), .mem_data_out(dout1),
    .Main_mem_ack(ack1), .mem_busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: every ack must match the oldest queued expectation.
  always @(negedge clk) begin
    if (ack0) begin
      if (sb0.size() == 0) begin
        check("dut0_unexpected_ack", {31'd0, ack0}, 32'd0);
      end else begin
        m0 = sb0.pop_front();
        check({m0.name, "_ack_cycle"}, cyc, m0.ack_cyc);
        if (m0.is_read) check({m0.name, "_data"}, dout0, m0.data);
      end
    end
  end

  always @(negedge clk) begin
    if (ack1) begin
      if (sb1.size() == 0) begin
        check("dut1_unexpected_ack", {31'd0, ack1}, 32'd0);
      end else begin
        m1 = sb1.pop_front();
        check({m1.name, "_ack_cycle"}, cyc, m1.ack_cyc);
        if (m1.is_read) check({m1.name, "_data"}, dout1, m1.data);
      end
    end
  end

  // Waits (bounded) for the next ack, counting cycles with busy high on the way.
  task automatic wait_ack(input int which, input string name, input bit scramble,
                          output int busy_cycles);
    bit seen;
    seen = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if ((which == 0) ? busy0 : busy1) busy_cycles++;
      if ((which == 0) ? ack0 : ack1) seen = 1'b1;
      if (scramble && i == 0) begin
        addr0 = 32'hFFFF_FFFC;
        din0  = ~din0;
      end
    end
    if (!seen) check({name, "_ack_timeout"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic write0(input logic [31:0] a, input logic [31:0] d, input string name,
                        input bit scramble);
    int busy;
    wr0 = 1'b1; addr0 = a; din0 = d;
    sb0.push_back('{name: name, is_read: 1'b0, data: 32'h0, ack_cyc: cyc + WL0});
    wait_ack(0, name, scramble, busy);
    wr0 = 1'b0;
    check({name, "_busy_cycles"}, busy, WL0);
    @(negedge clk);
    check({name, "_busy_after"}, {31'd0, busy0}, 32'd0);
  endtask

  task automatic read0(input logic [31:0] a, input logic [31:0] d, input string name,
                       input bit scramble);
    int busy;
    rd0 = 1'b1; addr0 = a;
    sb0.push_back('{name: name, is_read: 1'b1, data: d, ack_cyc: cyc + RL0});
    wait_ack(0, name, scramble, busy);
    rd0 = 1'b0;
    check({name, "_busy_cycles"}, busy, RL0);
    @(negedge clk);
    check({name, "_busy_after"}, {31'd0, busy0}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    int c;
    reset = 1'b0;
    rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; din0 = '0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; din1 = '0;
    repeat (2) @(negedge clk);
    check("reset_ack", {31'd0, ack0}, 32'd0);
    check("reset_busy", {31'd0, busy0}, 32'd0);
    check("reset_dout", dout0, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Write then read back, with inputs scrambled after acceptance.
    write0(32'h10, 32'hDEAD_BEEF, "wr_basic", 1'b1);
    check("dout_unchanged_by_write", dout0, 32'h0);
    read0(32'h10, 32'hDEAD_BEEF, "rd_basic", 1'b1);

    // Both requests high: write first, held read follows after one idle cycle.
    c = cyc;
    rd0 = 1'b1; wr0 = 1'b1; addr0 = 32'h20; din0 = 32'h1234_5678;
    sb0.push_back('{name: "sim_wr", is_read: 1'b0, data: 32'h0, ack_cyc: c + 4});
    sb0.push_back('{name: "sim_rd", is_read: 1'b1, data: 32'h1234_5678, ack_cyc: c + 9});
    wait_ack(0, "sim_wr", 1'b0, busy);
    wr0 = 1'b0;
    check("sim_wr_busy_cycles", busy, 4);
    wait_ack(0, "sim_rd", 1'b0, busy);
    rd0 = 1'b0;
    check("sim_rd_busy_cycles", busy, 4);
    @(negedge clk);
    check("sim_busy_after", {31'd0, busy0}, 32'd0);

    // Address wrap modulo 256 words, byte offset ignored.
    write0(32'h400, 32'hA5A5_A5A5, "wr_wrap", 1'b0);
    read0(32'h0, 32'hA5A5_A5A5, "rd_wrap0", 1'b0);
    read0(32'h3, 32'hA5A5_A5A5, "rd_wrap3", 1'b0);

    // Abort a write after two WAIT cycles.
    write0(32'h8, 32'h1111_1111, "wr_prior", 1'b0);
    wr0 = 1'b1; addr0 = 32'h8; din0 = 32'h55;
    repeat (2) @(negedge clk);
    wr0 = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy0}, 32'd0);
    check("abort_ack", {31'd0, ack0}, 32'd0);
    check("abort_dout", dout0, 32'hA5A5_A5A5);
    repeat (3) @(negedge clk);
    read0(32'h8, 32'h1111_1111, "rd_after_abort", 1'b0);

    // Reset asserted during WRITE_WAIT: outputs clear at once, word untouched.
    wr0 = 1'b1; addr0 = 32'h10; din0 = 32'h7777_7777;
    repeat (2) @(negedge clk);
    check("pre_reset_busy", {31'd0, busy0}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midreset_ack", {31'd0, ack0}, 32'd0);
    check("midreset_busy", {31'd0, busy0}, 32'd0);
    check("midreset_dout", dout0, 32'h0);
    wr0 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    read0(32'h10, 32'hDEAD_BEEF, "rd_after_reset", 1'b0);

    // Second instance: read latency 1, write latency 2, 16 words.
    c = cyc;
    wr1 = 1'b1; addr1 = 32'h44; din1 = 32'hCAFE_F00D;
    sb1.push_back('{name: "l1_wr", is_read: 1'b0, data: 32'h0, ack_cyc: c + 2});
    wait_ack(1, "l1_wr", 1'b0, busy);
    wr1 = 1'b0;
    check("l1_wr_busy_cycles", busy, 2);
    @(negedge clk);
    check("l1_dout_after_write", dout1, 32'h0);

    c = cyc;
    rd1 = 1'b1; addr1 = 32'h4;
    sb1.push_back('{name: "l1_rd_a", is_read: 1'b1, data: 32'hCAFE_F00D, ack_cyc: c + 1});
    sb1.push_back('{name: "l1_rd_b", is_read: 1'b1, data: 32'hCAFE_F00D, ack_cyc: c + 3});
    wait_ack(1, "l1_rd_a", 1'b0, busy);
    check("l1_rd_a_busy_cycles", busy, 1);
    wait_ack(1, "l1_rd_b", 1'b0, busy);
    rd1 = 1'b0;
    check("l1_rd_b_busy_cycles", busy, 1);
    @(negedge clk);
    check("l1_busy_after", {31'd0, busy1}, 32'd0);

    repeat (3) @(negedge clk);
    check("sb0_drained", sb0.size(), 32'd0);
    check("sb1_drained", sb1.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
